// File: rtl/nv_ram_fifo_ctrl_80x9.sv
// 80x9 FIFO controller for an external single-port-pair RAM with a registered
// output stage. Entries live in the RAM; a 3-entry output buffer hides the
// 3-cycle RAM read latency, and an empty FIFO lets pushes bypass the RAM array
// by loading the RAM output register directly.
module nv_ram_fifo_ctrl_80x9 (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_pvld,
    output logic        wr_prdy,
    input  logic [8:0]  wr_pd,
    output logic        rd_pvld,
    input  logic        rd_prdy,
    output logic [8:0]  rd_pd,
    output logic [6:0]  ram_wa,
    output logic        ram_we,
    output logic [8:0]  ram_di,
    output logic [6:0]  ram_ra,
    output logic        ram_re,
    output logic        ram_ore,
    input  logic [8:0]  ram_dout,
    output logic        ram_byp_sel,
    output logic [8:0]  ram_dbyp,
    input  logic [31:0] pwrbus_ram_pd,
    output logic [31:0] ram_pwrbus_pd
);

    localparam logic [6:0] DEPTH_C   = 7'd80;
    localparam logic [6:0] LAST_IDX_C = 7'd79;

    // Pointer increment with wrap at the last RAM entry.
    function automatic logic [6:0] next_ptr(input logic [6:0] ptr);
        if (ptr == LAST_IDX_C) begin
            next_ptr = 7'd0;
        end else begin
            next_ptr = ptr + 7'd1;
        end
    endfunction

    logic [6:0]       wr_ptr_r;
    logic [6:0]       rd_ptr_r;
    logic [6:0]       ram_cnt_r;
    logic             re_d1_r;     // read issued last cycle: its ore is this cycle
    logic             cap_r;       // ore last cycle: ram_dout is valid this cycle
    logic [1:0]       occ_r;
    logic [2:0][8:0]  buf_r;

    logic             push_s;
    logic             pop_s;
    logic [2:0]       busy_s;
    logic             credit_s;
    logic             rd_issue_s;
    logic             bypass_s;
    logic             wr_en_s;
    logic [1:0]       occ_tmp_s;
    logic [1:0]       occ_nxt_s;
    logic [2:0][8:0]  buf_nxt_s;

    assign wr_prdy       = (!reset) && (ram_cnt_r < DEPTH_C);
    assign rd_pvld       = (occ_r != 2'd0);
    assign rd_pd         = buf_r[0];
    assign ram_wa        = wr_ptr_r;
    assign ram_di        = wr_pd;
    assign ram_we        = wr_en_s;
    assign ram_ra        = rd_ptr_r;
    assign ram_re        = rd_issue_s;
    assign ram_ore       = re_d1_r | bypass_s;
    assign ram_byp_sel   = bypass_s;
    assign ram_dbyp      = bypass_s ? wr_pd : 9'd0;
    assign ram_pwrbus_pd = pwrbus_ram_pd;

    // Handshakes, output-buffer credit, read issue and bypass decision.
    always_comb begin
        push_s     = wr_pvld & wr_prdy;
        pop_s      = rd_pvld & rd_prdy;
        // Slots held by buffered data plus both pipeline stages; a pop this
        // cycle frees one.
        busy_s     = {1'b0, occ_r} + {2'b00, re_d1_r} + {2'b00, cap_r} - {2'b00, pop_s};
        credit_s   = (busy_s < 3'd3);
        rd_issue_s = (ram_cnt_r != 7'd0) && credit_s;
        // Bypass may not collide with the ore slot of last cycle's read.
        bypass_s   = push_s && (ram_cnt_r == 7'd0) && (!re_d1_r) && credit_s;
        wr_en_s    = push_s && (!bypass_s);
    end

    // Output buffer update: shift out on pop, then append captured RAM data.
    always_comb begin
        buf_nxt_s = buf_r;
        occ_tmp_s = occ_r;
        if (pop_s) begin
            buf_nxt_s[0] = buf_r[1];
            buf_nxt_s[1] = buf_r[2];
            buf_nxt_s[2] = 9'd0;
            occ_tmp_s    = occ_r - 2'd1;
        end else begin
            occ_tmp_s    = occ_r;
        end
        if (cap_r) begin
            case (occ_tmp_s)
                2'd0:    buf_nxt_s[0] = ram_dout;
                2'd1:    buf_nxt_s[1] = ram_dout;
                2'd2:    buf_nxt_s[2] = ram_dout;
                default: buf_nxt_s[2] = ram_dout;
            endcase
            occ_nxt_s = occ_tmp_s + 2'd1;
        end else begin
            occ_nxt_s = occ_tmp_s;
        end
    end

    // Pointers, RAM entry count and read pipeline state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= 7'd0;
            rd_ptr_r  <= 7'd0;
            ram_cnt_r <= 7'd0;
            re_d1_r   <= 1'b0;
            cap_r     <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (rd_issue_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            ram_cnt_r <= ram_cnt_r + {6'd0, wr_en_s} - {6'd0, rd_issue_s};
            re_d1_r   <= rd_issue_s;
            cap_r     <= ram_ore;
        end
    end

    // Output buffer storage and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_r <= 2'd0;
            buf_r <= '0;
        end else begin
            occ_r <= occ_nxt_s;
            buf_r <= buf_nxt_s;
        end
    end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_80x9.sv
// Bench for nv_ram_fifo_ctrl_80x9: behavioural RAM with registered output,
// a queue-based FIFO model checked every cycle, and directed scenarios with
// hand-computed literal expectations.
module tb_nv_ram_fifo_ctrl_80x9;

    logic        clk;
    logic        reset;
    logic        wr_pvld;
    logic        wr_prdy;
    logic [8:0]  wr_pd;
    logic        rd_pvld;
    logic        rd_prdy;
    logic [8:0]  rd_pd;
    logic [6:0]  ram_wa;
    logic        ram_we;
    logic [8:0]  ram_di;
    logic [6:0]  ram_ra;
    logic        ram_re;
    logic        ram_ore;
    logic [8:0]  ram_dout;
    logic        ram_byp_sel;
    logic [8:0]  ram_dbyp;
    logic [31:0] pwrbus_ram_pd;
    logic [31:0] ram_pwrbus_pd;

    nv_ram_fifo_ctrl_80x9 dut (
        .clk(clk), .reset(reset),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout),
        .ram_byp_sel(ram_byp_sel), .ram_dbyp(ram_dbyp),
        .pwrbus_ram_pd(pwrbus_ram_pd), .ram_pwrbus_pd(ram_pwrbus_pd)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural attached RAM: write and address register on edge N,
    // output register loads on the ore edge and otherwise holds.
    logic [8:0] mem [0:127];
    logic [6:0] ra_q;
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 9'h1FF;
        ra_q = 7'd0;
        ram_dout = 9'd0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
        if (ram_ore) ram_dout <= ram_byp_sel ? ram_dbyp : mem[ra_q];
    end

    // FIFO model: every accepted push queued, every pop must return the front.
    logic [8:0] q [$];
    logic [8:0] pop_log [$];
    int push_cnt = 0;
    int ram_held = 0;
    int exp_wa = 0;
    int exp_ra = 0;
    logic prev_re = 1'b0;

    // Per-cycle comparison of DUT outputs against the model (inputs stable).
    always @(negedge clk) begin
        logic push, pop;
        if (reset) begin
            chk("rst_wr_prdy", {31'd0, wr_prdy}, 32'd0);
            chk("rst_rd_pvld", {31'd0, rd_pvld}, 32'd0);
            chk("rst_rd_pd", {23'd0, rd_pd}, 32'd0);
            chk("rst_ram_en", {29'd0, ram_we, ram_re, ram_ore}, 32'd0);
            chk("rst_byp", {22'd0, ram_byp_sel, ram_dbyp}, 32'd0);
            q.delete();
            ram_held = 0;
            exp_wa = 0;
            exp_ra = 0;
            prev_re = 1'b0;
        end else begin
            push = wr_pvld && wr_prdy;
            pop  = rd_pvld && rd_prdy;
            chk("pwrbus", ram_pwrbus_pd, pwrbus_ram_pd);
            chk("pvld_stale", {31'd0, rd_pvld && (q.size() == 0)}, 32'd0);
            chk("wr_prdy", {31'd0, wr_prdy}, {31'd0, ram_held < 80});
            chk("ore_timing", {31'd0, ram_ore}, {31'd0, prev_re | ram_byp_sel});
            chk("byp_on_re_slot", {31'd0, prev_re & ram_byp_sel}, 32'd0);
            chk("byp_cond", {31'd0, ram_byp_sel && !(push && ram_held == 0)}, 32'd0);
            chk("ram_we", {31'd0, ram_we}, {31'd0, push && !ram_byp_sel});
            chk("dbyp", {23'd0, ram_dbyp}, ram_byp_sel ? {23'd0, wr_pd} : 32'd0);
            chk("re_empty", {31'd0, ram_re && (ram_held == 0)}, 32'd0);
            if (pop) begin
                if (q.size() == 0) begin
                    chk("pop_underflow", 32'd1, 32'd0);
                end else begin
                    chk("pop_data", {23'd0, rd_pd}, {23'd0, q[0]});
                    void'(q.pop_front());
                end
                pop_log.push_back(rd_pd);
            end
            if (ram_we) begin
                chk("ram_wa", {25'd0, ram_wa}, exp_wa);
                chk("ram_di", {23'd0, ram_di}, {23'd0, wr_pd});
                exp_wa = (exp_wa + 1) % 80;
                ram_held++;
            end
            if (ram_re) begin
                chk("ram_ra", {25'd0, ram_ra}, exp_ra);
                exp_ra = (exp_ra + 1) % 80;
                ram_held--;
            end
            if (push) begin
                q.push_back(wr_pd);
                push_cnt++;
            end
            prev_re = ram_re;
        end
    end

    task automatic wait_pops(input int n, input int budget);
        int k;
        k = 0;
        while (pop_log.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("wait_pops", pop_log.size(), n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int gaps;
        reset = 1'b1;
        wr_pvld = 1'b0;
        wr_pd = 9'd0;
        rd_prdy = 1'b0;
        pwrbus_ram_pd = 32'hA5C3_0F1E;

        // Reset state
        repeat (3) tick();
        chk("reset_wr_prdy", {31'd0, wr_prdy}, 32'd0);
        chk("reset_rd_pvld", {31'd0, rd_pvld}, 32'd0);
        chk("reset_ram_ore", {31'd0, ram_ore}, 32'd0);
        reset = 1'b0;
        #1;
        chk("wr_prdy_after_reset", {31'd0, wr_prdy}, 32'd1);

        // Bypass latency: single push 0x1A5
        tick();
        rd_prdy = 1'b1;
        wr_pvld = 1'b1;
        wr_pd = 9'h1A5;
        #1;
        chk("byp_sel", {31'd0, ram_byp_sel}, 32'd1);
        chk("byp_ore", {31'd0, ram_ore}, 32'd1);
        chk("byp_dbyp", {23'd0, ram_dbyp}, 32'h1A5);
        chk("byp_no_we", {31'd0, ram_we}, 32'd0);
        tick();
        wr_pvld = 1'b0;
        chk("byp_pvld_1cyc", {31'd0, rd_pvld}, 32'd0);
        tick();
        chk("byp_pvld_2cyc", {31'd0, rd_pvld}, 32'd1);
        chk("byp_rd_pd", {23'd0, rd_pd}, 32'h1A5);
        tick();
        chk("byp_popped", {31'd0, rd_pvld}, 32'd0);

        // Fill: 83 accepted, then full
        rd_prdy = 1'b0;
        base = push_cnt;
        for (int i = 0; i < 100; i++) begin
            tick();
            wr_pvld = 1'b1;
            wr_pd = 9'(push_cnt - base);
        end
        tick();
        wr_pvld = 1'b0;
        chk("fill_count", push_cnt - base, 83);
        chk("fill_wr_prdy", {31'd0, wr_prdy}, 32'd0);
        chk("fill_head", {23'd0, rd_pd}, 32'd0);
        pop_log.delete();
        rd_prdy = 1'b1;
        wait_pops(83, 400);
        if (pop_log.size() >= 83) begin
            chk("fill_first", {23'd0, pop_log[0]}, 32'd0);
            chk("fill_last", {23'd0, pop_log[82]}, 32'd82);
        end
        repeat (4) tick();
        chk("fill_drained", {31'd0, rd_pvld}, 32'd0);

        // Wrap: backlog of 10, then 200 pushes streamed with rd_prdy=1
        pop_log.delete();
        base = push_cnt;
        rd_prdy = 1'b0;
        gaps = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (i >= 12 && !rd_pvld) gaps++;
            if (push_cnt - base >= 200) break;
            rd_prdy = (i >= 10);
            wr_pvld = 1'b1;
            wr_pd = 9'(push_cnt - base);
        end
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        chk("wrap_no_gaps", gaps, 0);
        wait_pops(200, 100);
        if (pop_log.size() >= 200) begin
            chk("wrap_last", {23'd0, pop_log[199]}, 32'd199);
        end

        // Backpressure: random push, 30% pop
        pop_log.delete();
        base = push_cnt;
        for (int i = 0; i < 600; i++) begin
            tick();
            wr_pvld = 1'($urandom_range(0, 1));
            wr_pd = 9'($urandom);
            rd_prdy = ($urandom_range(0, 9) < 3);
        end
        tick();
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        wait_pops(push_cnt - base, 400);
        repeat (4) tick();
        chk("rand_model_empty", q.size(), 0);
        chk("rand_drained", {31'd0, rd_pvld}, 32'd0);

        // Reset mid-stream: 43 pushed (3 buffered, 40 in RAM), 2 reads in flight
        rd_prdy = 1'b0;
        base = push_cnt;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (push_cnt - base >= 43) break;
            wr_pvld = 1'b1;
            wr_pd = 9'(9'h0A0 + 9'(push_cnt - base));
        end
        wr_pvld = 1'b0;
        chk("mid_count", push_cnt - base, 43);
        repeat (2) tick();
        rd_prdy = 1'b1;
        #1;
        chk("mid_re_a", {31'd0, ram_re}, 32'd1);
        tick();
        #1;
        chk("mid_re_b", {31'd0, ram_re}, 32'd1);
        tick();
        rd_prdy = 1'b0;
        chk("mid_ore_pending", {31'd0, ram_ore}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ore", {31'd0, ram_ore}, 32'd0);
        chk("mid_rst_pvld", {31'd0, rd_pvld}, 32'd0);
        chk("mid_rst_pd", {23'd0, rd_pd}, 32'd0);
        chk("mid_rst_prdy", {31'd0, wr_prdy}, 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("mid_wr_prdy", {31'd0, wr_prdy}, 32'd1);
        pop_log.delete();
        rd_prdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            wr_pvld = 1'b1;
            wr_pd = 9'(9'h100 + 9'(i));
        end
        tick();
        wr_pvld = 1'b0;
        wait_pops(5, 50);
        if (pop_log.size() >= 5) begin
            chk("mid_first", {23'd0, pop_log[0]}, 32'h100);
            chk("mid_last", {23'd0, pop_log[4]}, 32'h104);
        end
        repeat (6) tick();
        chk("mid_no_stale", {31'd0, rd_pvld}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
